// File: rtl/fp_result_checker.sv
// In-order result checker for the FP-unit vector stream.
// Expected entries are queued; results are compared against the oldest entry.
module fp_result_checker #(
    parameter int W     = 64,
    parameter int FW    = 5,
    parameter int DEPTH = 16,
    parameter int CNTW  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            check_flags,
    input  logic            exp_valid,
    output logic            exp_ready,
    input  logic [W-1:0]    exp_result,
    input  logic [FW-1:0]   exp_flags,
    input  logic            exp_last,
    input  logic            res_valid,
    output logic            res_ready,
    input  logic [W-1:0]    res_result,
    input  logic [FW-1:0]   res_flags,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [CNTW-1:0] vec_count,
    output logic [CNTW-1:0] err_count,
    output logic            fail_valid,
    output logic [CNTW-1:0] fail_index,
    output logic [W-1:0]    fail_got,
    output logic [W-1:0]    fail_exp,
    output logic [FW-1:0]   fail_flags_got,
    output logic [FW-1:0]   fail_flags_exp
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = W + FW + 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [CNTW-1:0] vec_q, vec_d;
    logic [CNTW-1:0] err_q, err_d;
    logic            fval_q, fval_d;
    logic [CNTW-1:0] fidx_q, fidx_d;
    logic [W-1:0]    fgot_q, fgot_d;
    logic [W-1:0]    fexp_q, fexp_d;
    logic [FW-1:0]   ffg_q, ffg_d;
    logic [FW-1:0]   ffe_q, ffe_d;

    logic            run;
    logic            full;
    logic            empty;
    logic            push;
    logic            cmp;
    logic            mismatch;
    logic [W-1:0]    head_result;
    logic [FW-1:0]   head_flags;
    logic            head_last;

    assign run   = (state_q == S_RUN);
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);

    // start blocks both handshakes so the flush cannot race a transfer
    assign exp_ready = run && !full && !start;
    assign res_ready = run && !empty && !start;
    assign push      = exp_valid && exp_ready;
    assign cmp       = res_valid && res_ready;

    assign {head_result, head_flags, head_last} = mem_q[rd_ptr_q];

    assign mismatch = (res_result != head_result) ||
                      (check_flags && (res_flags != head_flags));

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        vec_d    = vec_q;
        err_d    = err_q;
        fval_d   = fval_q;
        fidx_d   = fidx_q;
        fgot_d   = fgot_q;
        fexp_d   = fexp_q;
        ffg_d    = ffg_q;
        ffe_d    = ffe_q;
        if (start) begin
            state_d  = S_RUN;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            vec_d    = '0;
            err_d    = '0;
            fval_d   = 1'b0;
            fidx_d   = '0;
            fgot_d   = '0;
            fexp_d   = '0;
            ffg_d    = '0;
            ffe_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (cmp) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                if (vec_q != '1) begin
                    vec_d = vec_q + 1'b1;
                end
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fval_q) begin
                        fval_d = 1'b1;
                        fidx_d = vec_q;
                        fgot_d = res_result;
                        fexp_d = head_result;
                        ffg_d  = res_flags;
                        ffe_d  = head_flags;
                    end
                end
                if (head_last) begin
                    state_d = S_DONE;
                end
            end
            if (push && !cmp) begin
                cnt_d = cnt_q + 1'b1;
            end else if (cmp && !push) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            vec_q    <= '0;
            err_q    <= '0;
            fval_q   <= 1'b0;
            fidx_q   <= '0;
            fgot_q   <= '0;
            fexp_q   <= '0;
            ffg_q    <= '0;
            ffe_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            vec_q    <= vec_d;
            err_q    <= err_d;
            fval_q   <= fval_d;
            fidx_q   <= fidx_d;
            fgot_q   <= fgot_d;
            fexp_q   <= fexp_d;
            ffg_q    <= ffg_d;
            ffe_q    <= ffe_d;
        end
    end

    // storage only; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {exp_result, exp_flags, exp_last};
        end
    end

    assign busy           = run;
    assign done           = (state_q == S_DONE);
    assign pass           = done && (err_q == '0);
    assign vec_count      = vec_q;
    assign err_count      = err_q;
    assign fail_valid     = fval_q;
    assign fail_index     = fidx_q;
    assign fail_got       = fgot_q;
    assign fail_exp       = fexp_q;
    assign fail_flags_got = ffg_q;
    assign fail_flags_exp = ffe_q;

endmodule

// File: tb/tb_fp_result_checker.sv
// Scoreboard bench for fp_result_checker: random streams, queue-based model.
module tb_fp_result_checker;

    localparam int W     = 64;
    localparam int FW    = 5;
    localparam int DEPTH = 16;
    localparam int CNTW  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            check_flags;
    logic            exp_valid;
    logic            exp_ready;
    logic [W-1:0]    exp_result;
    logic [FW-1:0]   exp_flags;
    logic            exp_last;
    logic            res_valid;
    logic            res_ready;
    logic [W-1:0]    res_result;
    logic [FW-1:0]   res_flags;
    logic            busy;
    logic            done;
    logic            pass;
    logic [CNTW-1:0] vec_count;
    logic [CNTW-1:0] err_count;
    logic            fail_valid;
    logic [CNTW-1:0] fail_index;
    logic [W-1:0]    fail_got;
    logic [W-1:0]    fail_exp;
    logic [FW-1:0]   fail_flags_got;
    logic [FW-1:0]   fail_flags_exp;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    fp_result_checker #(
        .W(W), .FW(FW), .DEPTH(DEPTH), .CNTW(CNTW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .check_flags(check_flags),
        .exp_valid(exp_valid),
        .exp_ready(exp_ready),
        .exp_result(exp_result),
        .exp_flags(exp_flags),
        .exp_last(exp_last),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_result(res_result),
        .res_flags(res_flags),
        .busy(busy),
        .done(done),
        .pass(pass),
        .vec_count(vec_count),
        .err_count(err_count),
        .fail_valid(fail_valid),
        .fail_index(fail_index),
        .fail_got(fail_got),
        .fail_exp(fail_exp),
        .fail_flags_got(fail_flags_got),
        .fail_flags_exp(fail_flags_exp)
    );

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        n_tot++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h required %h", nm, got, want);
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct packed {
        logic [W-1:0]  r;
        logic [FW-1:0] f;
        logic          l;
    } ent_t;

    ent_t        m_q[$];
    bit          m_run, m_done, m_fv;
    int          m_vec, m_err, m_fidx;
    logic [W-1:0]  m_fgot, m_fexp;
    logic [FW-1:0] m_ffg, m_ffe;

    task automatic m_clear();
        m_q.delete();
        m_vec = 0; m_err = 0; m_fv = 0; m_fidx = 0;
        m_fgot = '0; m_fexp = '0; m_ffg = '0; m_ffe = '0;
    endtask

    always @(negedge clk) begin
        ent_t e;
        bit   mer, mrr, bad;
        if (!reset) begin
            m_clear();
            m_run = 0;
            m_done = 0;
        end
        mer = m_run && (m_q.size() < DEPTH) && !start;
        mrr = m_run && (m_q.size() != 0) && !start;
        chk("exp_ready", exp_ready, mer);
        chk("res_ready", res_ready, mrr);
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("pass", pass, m_done && (m_err == 0));
        chk("vec_count", vec_count, m_vec);
        chk("err_count", err_count, m_err);
        chk("fail_valid", fail_valid, m_fv);
        chk("fail_index", fail_index, m_fidx);
        chk("fail_got", fail_got, m_fgot);
        chk("fail_exp", fail_exp, m_fexp);
        chk("fail_flags_got", fail_flags_got, m_ffg);
        chk("fail_flags_exp", fail_flags_exp, m_ffe);
        if (reset) begin
            if (start) begin
                m_clear();
                m_run = 1;
                m_done = 0;
            end else begin
                if (res_valid && mrr) begin
                    e = m_q.pop_front();
                    bad = (res_result != e.r) ||
                          (check_flags && (res_flags != e.f));
                    if (bad) begin
                        if (!m_fv) begin
                            m_fv = 1; m_fidx = m_vec;
                            m_fgot = res_result; m_fexp = e.r;
                            m_ffg = res_flags; m_ffe = e.f;
                        end
                        m_err++;
                    end
                    m_vec++;
                    if (e.l) begin
                        m_run = 0;
                        m_done = 1;
                    end
                end
                if (exp_valid && mer) begin
                    e = {exp_result, exp_flags, exp_last};
                    m_q.push_back(e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [W-1:0]  v_res [64];
    logic [FW-1:0] v_flg [64];
    logic [W-1:0]  g_res [64];
    logic [FW-1:0] g_flg [64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1; exp_valid = 1; res_valid = 1;
        @(negedge clk);
        chk("start_exp_ready", exp_ready, 0);
        chk("start_res_ready", res_ready, 0);
        tick();
        start = 0; exp_valid = 0; res_valid = 0;
    endtask

    task automatic fill_same(input int n);
        for (int i = 0; i < n; i++) begin
            v_res[i] = 64'h3FF0000000000000;
            v_flg[i] = '0;
            g_res[i] = v_res[i];
            g_flg[i] = v_flg[i];
        end
    endtask

    task automatic fill_rand(input int n, input int err_pct);
        for (int i = 0; i < n; i++) begin
            v_res[i] = {$urandom, $urandom};
            v_flg[i] = FW'($urandom);
            g_res[i] = v_res[i];
            g_flg[i] = v_flg[i];
            if ($urandom_range(99) < err_pct) begin
                if ($urandom_range(1) == 1)
                    g_res[i] = v_res[i] ^ (64'd1 << $urandom_range(63));
                else
                    g_flg[i] = v_flg[i] ^ (5'd1 << $urandom_range(4));
            end
        end
    endtask

    task automatic play(input int n, input int stop, input int pv,
                        input int pr, input int ei0, input int ri0);
        int ei = ei0;
        int ri = ri0;
        int cyc = 0;
        bit ea, ra;
        while (ri < stop && cyc < 3000) begin
            exp_valid = (ei < n) && ($urandom_range(99) < pv);
            if (ei < n) begin
                exp_result = v_res[ei];
                exp_flags  = v_flg[ei];
                exp_last   = (ei == n - 1);
            end
            res_valid = (ri < n) && ($urandom_range(99) < pr);
            if (ri < n) begin
                res_result = g_res[ri];
                res_flags  = g_flg[ri];
            end
            @(negedge clk);
            ea = exp_valid && exp_ready;
            ra = res_valid && res_ready;
            tick();
            if (ea) ei++;
            if (ra) ri++;
            cyc++;
        end
        exp_valid = 0;
        res_valid = 0;
        chk("play_progress", ri, stop);
    endtask

    initial begin
        int ei;
        int n;
        bit ea;
        reset = 0; start = 0; check_flags = 1;
        exp_valid = 0; exp_result = '0; exp_flags = '0; exp_last = 0;
        res_valid = 0; res_result = '0; res_flags = '0;
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_vec", vec_count, 0);
        chk("rst_exp_ready", exp_ready, 0);
        reset = 1;
        tick();

        // pass run
        fill_same(4);
        do_start();
        play(4, 4, 100, 100, 0, 0);
        chk("pr_done", done, 1);
        chk("pr_pass", pass, 1);
        chk("pr_vec", vec_count, 4);
        chk("pr_err", err_count, 0);
        chk("pr_fv", fail_valid, 0);

        // single error on vector 2
        fill_same(4);
        g_res[2] = 64'h3FF0000000000001;
        do_start();
        play(4, 4, 100, 100, 0, 0);
        chk("se_err", err_count, 1);
        chk("se_fv", fail_valid, 1);
        chk("se_idx", fail_index, 2);
        chk("se_got", fail_got, 64'h3FF0000000000001);
        chk("se_exp", fail_exp, 64'h3FF0000000000000);
        chk("se_pass", pass, 0);

        // flag mask
        fill_same(4);
        v_flg[1] = 5'b00001;
        check_flags = 0;
        do_start();
        play(4, 4, 100, 100, 0, 0);
        chk("fm0_err", err_count, 0);
        chk("fm0_pass", pass, 1);
        check_flags = 1;
        do_start();
        play(4, 4, 100, 100, 0, 0);
        chk("fm1_err", err_count, 1);
        chk("fm1_fexp", fail_flags_exp, 5'b00001);
        chk("fm1_fgot", fail_flags_got, 5'b00000);
        chk("fm1_idx", fail_index, 1);

        // full / backpressure / wrap over 40 vectors
        fill_rand(40, 0);
        do_start();
        ei = 0;
        for (int c = 0; c < 20; c++) begin
            exp_valid  = 1;
            exp_result = v_res[ei];
            exp_flags  = v_flg[ei];
            exp_last   = (ei == 39);
            @(negedge clk);
            ea = exp_valid && exp_ready;
            tick();
            if (ea) ei++;
        end
        chk("full_accepts", ei, 16);
        res_valid = 1; res_result = g_res[0]; res_flags = g_flg[0];
        @(negedge clk);
        chk("full_pp_exp_ready", exp_ready, 0);
        chk("full_pp_res_ready", res_ready, 1);
        tick();
        res_valid = 0;
        @(negedge clk);
        chk("full_after_pop_exp_ready", exp_ready, 1);
        tick();
        exp_valid = 0;
        play(40, 40, 70, 70, 17, 1);
        chk("wrap_done", done, 1);
        chk("wrap_vec", vec_count, 40);
        chk("wrap_err", err_count, 0);

        // empty, no bypass
        fill_rand(2, 0);
        do_start();
        res_valid = 1; res_result = g_res[0]; res_flags = g_flg[0];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("empty_res_ready", res_ready, 0);
            tick();
        end
        exp_valid = 1; exp_result = v_res[0]; exp_flags = v_flg[0];
        exp_last = 0;
        @(negedge clk);
        chk("nobypass_same_cycle", res_ready, 0);
        tick();
        exp_valid = 0;
        @(negedge clk);
        chk("nobypass_next_cycle", res_ready, 1);
        tick();
        res_valid = 0;
        @(negedge clk);
        chk("nobypass_vec", vec_count, 1);
        chk("nobypass_empty_again", res_ready, 0);
        tick();

        // restart mid-run
        fill_rand(8, 0);
        g_res[1] = g_res[1] ^ 64'h1;
        do_start();
        play(8, 3, 100, 100, 0, 0);
        chk("rs_vec_pre", vec_count, 3);
        chk("rs_err_pre", err_count, 1);
        do_start();
        @(negedge clk);
        chk("rs_vec", vec_count, 0);
        chk("rs_err", err_count, 0);
        chk("rs_fv", fail_valid, 0);
        chk("rs_empty", res_ready, 0);
        chk("rs_exp_ready", exp_ready, 1);
        tick();

        // random runs
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(40, 5);
            fill_rand(n, 15);
            check_flags = 1'($urandom_range(1));
            do_start();
            play(n, n, $urandom_range(100, 30), $urandom_range(100, 30), 0, 0);
            chk("rand_done", done, 1);
            chk("rand_vec", vec_count, n);
        end
        check_flags = 1;

        // asynchronous reset mid-run
        fill_rand(20, 0);
        g_res[0] = g_res[0] ^ 64'h8000000000000000;
        do_start();
        play(20, 5, 100, 100, 0, 0);
        chk("ar_vec_pre", vec_count, 5);
        @(posedge clk);
        #3;
        reset = 0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_vec", vec_count, 0);
        chk("ar_err", err_count, 0);
        chk("ar_fv", fail_valid, 0);
        chk("ar_fidx", fail_index, 0);
        chk("ar_fgot", fail_got, 0);
        chk("ar_exp_ready", exp_ready, 0);
        chk("ar_res_ready", res_ready, 0);
        tick();
        reset = 1;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
